// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Bits needed to hold max(a, b, 1).
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_mgr_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after two clk edges.
module rst_sync (
  input  logic clk,
  input  logic rst_in,
  output logic rst_out
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= 1'b0;
      sync_q <= meta_q;
    end
  end

  assign rst_out = sync_q;

endmodule

// File: rtl/rst_seq_mgr.sv
// Staggered multi-channel reset sequencer with software restart and cause log.
// Optional watchdog restart is compiled in with `define RST_SEQ_WDT_EN.
module rst_seq_mgr
  import rst_seq_pkg::*;
#(
  parameter int N_CH     = 3,
  parameter int HOLD_CYC = 65535,
  parameter int STAGGER  = 256,
  parameter int WDT_CYC  = 2**24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sw_rst_req,
  input  logic            wdt_kick,
  output logic [N_CH-1:0] ch_rst,
  output logic            all_done,
  output logic [1:0]      rst_cause,
  output logic            wdt_fired
);

  localparam int CW = cnt_w(HOLD_CYC, STAGGER);
  localparam int IW = cnt_w(N_CH - 1, 1);
  localparam int WW = $clog2(WDT_CYC + 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] STAG_LD  = CW'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);
  localparam bit ONE_SHOT = (N_CH == 1) || (STAGGER == 0);

  logic rst_s;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N_CH-1:0] ch_rst_q, ch_rst_d;
  logic            all_done_q, all_done_d;
  logic [1:0]      cause_q, cause_d;
  logic            wdt_fired_q, wdt_fired_d;
  logic            wdt_expire, restart, cnt_zero;

  rst_sync u_sync (
    .clk    (clk),
    .rst_in (reset),
    .rst_out(rst_s)
  );

  assign restart  = sw_rst_req | wdt_expire;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      state_q     <= HOLD;
      cnt_q       <= HOLD_LD;
      idx_q       <= '0;
      ch_rst_q    <= '1;
      all_done_q  <= 1'b0;
      cause_q     <= CAUSE_EXT;
      wdt_fired_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ch_rst_q    <= ch_rst_d;
      all_done_q  <= all_done_d;
      cause_q     <= cause_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (restart) begin
      state_d = HOLD;
      cnt_d   = HOLD_LD;
      idx_d   = '0;
    end else begin
      case (state_q)
        HOLD: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - CW'(1);
          end else if (ONE_SHOT) begin
            state_d = RUN;
          end else begin
            state_d = RELEASE;
            cnt_d   = STAG_LD;
            idx_d   = IW'(1);
          end
        end
        RELEASE: begin
          if (!cnt_zero) begin
            cnt_d = cnt_q - CW'(1);
          end else if (idx_q == LAST_IDX) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + IW'(1);
            cnt_d = STAG_LD;
          end
        end
        RUN:     ;
        default: state_d = HOLD;
      endcase
    end
  end

  // Channels only ever drop here; the only way back up is a restart.
  always_comb begin
    ch_rst_d    = ch_rst_q;
    all_done_d  = (state_d == RUN);
    wdt_fired_d = wdt_expire;
    cause_d     = cause_q;
    if (sw_rst_req)      cause_d = CAUSE_SW;
    else if (wdt_expire) cause_d = CAUSE_WDT;
    if (restart) begin
      ch_rst_d = '1;
    end else if (cnt_zero) begin
      if (state_q == HOLD) begin
        ch_rst_d[0] = 1'b0;
        if (ONE_SHOT) ch_rst_d = '0;
      end else if (state_q == RELEASE) begin
        for (int k = 0; k < N_CH; k++)
          if (idx_q == IW'(k)) ch_rst_d[k] = 1'b0;
      end
    end
  end

`ifdef RST_SEQ_WDT_EN
  localparam logic [WW-1:0] WDT_LD = WW'(WDT_CYC - 1);

  logic [WW-1:0] wdt_q, wdt_d;

  // A kick on the expiry cycle wins and the watchdog simply reloads.
  assign wdt_expire = (state_q == RUN) && (wdt_q == '0) && !wdt_kick;

  always_comb begin
    wdt_d = wdt_q;
    if (state_q != RUN && state_d == RUN) wdt_d = WDT_LD;
    else if (state_q == RUN) begin
      if (wdt_kick)          wdt_d = WDT_LD;
      else if (wdt_q != '0)  wdt_d = wdt_q - WW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_s) begin
    if (rst_s) wdt_q <= WDT_LD;
    else       wdt_q <= wdt_d;
  end
`else
  logic [WW-1:0] unused_wdt;

  assign wdt_expire = 1'b0;
  assign unused_wdt = WW'(WDT_CYC) ^ {WW{wdt_kick}};
`endif

  assign ch_rst    = ch_rst_q;
  assign all_done  = all_done_q;
  assign rst_cause = cause_q;
  assign wdt_fired = wdt_fired_q;

endmodule
